// File: rtl/regfile_write_sequencer_if.sv
// Write-request handshake between write-back and the sequencer.
// master drives valid/addr/data; slave returns wr_ready.
interface regfile_write_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Buffers write requests and issues them one per clock to the 8x32 regfile.
// Ports: Clk, Rst_n, wr (request if), Dout/RE/BE to regfile, pending, busy.
// Option: WB_BYPASS_EN lets a request reach the outputs with zero latency.
module regfile_write_sequencer #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  regfile_write_sequencer_if.slave     wr,
  output logic [WIDTH-1:0]             Dout,
  output logic [7:0]                   RE,
  output logic                         BE,
  output logic [4:0]                   pending,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] FULL = 5'(DEPTH);

  logic [2:0]       addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [7:0]       re_q, re_d;
  logic             be_q, be_d;

  logic             push, pop, byp, enq, go, kill;
  logic [2:0]       iss_addr;
  logic [WIDTH-1:0] iss_data;

  always_comb begin
    push = wr.wr_valid && rdy_q;
    pop  = (cnt_q != 5'd0);
`ifdef WB_BYPASS_EN
    // Only an empty queue may be bypassed: a queued entry owns
    // the output registers on its pop edge, and order must hold.
    byp  = push && (cnt_q == 5'd0);
`else
    byp  = 1'b0;
`endif
    enq  = push && !byp;

    cnt_d = cnt_q + 5'(enq) - 5'(pop);
    wp_d  = enq ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    rdy_d = (cnt_d != FULL);

    iss_addr = wr.wr_addr;
    iss_data = wr.wr_data;
    if (pop) begin
      iss_addr = addr_mem[rp_q];
      iss_data = data_mem[rp_q];
    end
    go   = pop || byp;
    // R0 writes still pop and move Dout but strobe nothing.
    kill = (ZERO_R0 != 0) && (iss_addr == 3'd0);

    dout_d = go ? iss_data : dout_q;
    be_d   = go && !kill;
    re_d   = be_d ? (8'b1 << iss_addr) : 8'b0;
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      addr_mem[wp_q] <= wr.wr_addr;
      data_mem[wp_q] <= wr.wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      dout_q <= '0;
      re_q   <= '0;
      be_q   <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      dout_q <= dout_d;
      re_q   <= re_d;
      be_q   <= be_d;
    end
  end

  assign wr.wr_ready = rdy_q;
  assign Dout        = dout_q;
  assign RE          = re_q;
  assign BE          = be_q;
  assign pending     = cnt_q;
  assign busy        = (cnt_q != 5'd0) || be_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Checks two sequencers (ZERO_R0=1 and 0) against a queue model.
// Directed reset/write/burst/R0/mid-reset steps, then random traffic.
module tb_regfile_write_sequencer;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        v;
  logic [2:0]  a;
  logic [31:0] d;

  regfile_write_sequencer_if #(.WIDTH(32)) if0 ();
  regfile_write_sequencer_if #(.WIDTH(32)) if1 ();

  logic [31:0] dout0, dout1;
  logic [7:0]  re0, re1;
  logic        be0, be1, busy0, busy1;
  logic [4:0]  pend0, pend1;

  regfile_write_sequencer #(.DEPTH(DEPTH), .WIDTH(32), .ZERO_R0(1)) u0 (
    .Clk(clk), .Rst_n(rst_n), .wr(if0.slave),
    .Dout(dout0), .RE(re0), .BE(be0),
    .pending(pend0), .busy(busy0)
  );

  regfile_write_sequencer #(.DEPTH(DEPTH), .WIDTH(32), .ZERO_R0(0)) u1 (
    .Clk(clk), .Rst_n(rst_n), .wr(if1.slave),
    .Dout(dout1), .RE(re1), .BE(be1),
    .pending(pend1), .busy(busy1)
  );

  assign if0.wr_valid = v;
  assign if0.wr_addr  = a;
  assign if0.wr_data  = d;
  assign if1.wr_valid = v;
  assign if1.wr_addr  = a;
  assign if1.wr_data  = d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register blocks fed by each DUT
  logic [31:0] rb0 [8] = '{default: 32'h0};
  logic [31:0] rb1 [8] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (be0 && re0[i]) rb0[i] <= dout0;
      if (be1 && re1[i]) rb1[i] <= dout1;
    end
  end

  int checks = 0;
  int errors = 0;

  // reference model
  req_t        q[$];
  bit          mready;
  bit          mgo;
  logic [2:0]  maddr;
  logic [31:0] mdout;
  int          maxpend;

  task automatic model_reset();
    q.delete();
    mready = 1'b0;
    mgo    = 1'b0;
    maddr  = 3'd0;
    mdout  = 32'h0;
  endtask

  task automatic model_edge();
    bit   acc, empty0;
    req_t e;
    acc    = v && mready;
    empty0 = (q.size() == 0);
    mgo    = 1'b0;
    if (!empty0) begin
      e   = q.pop_front();
      mgo = 1'b1;
    end else if (BYP && acc) begin
      e   = '{addr: a, data: d};
      mgo = 1'b1;
    end
    if (acc && !(BYP && empty0)) q.push_back('{addr: a, data: d});
    mready = (q.size() != DEPTH);
    if (mgo) begin
      maddr = e.addr;
      mdout = e.data;
    end
    if (q.size() > maxpend) maxpend = q.size();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit       e0, e1;
    bit [7:0] r0, r1;
    int       p;
    e0 = mgo && (maddr != 3'd0);
    e1 = mgo;
    r0 = e0 ? (8'h1 << maddr) : 8'h0;
    r1 = e1 ? (8'h1 << maddr) : 8'h0;
    p  = q.size();
    chk("be0", 32'(be0), 32'(e0));
    chk("re0", 32'(re0), 32'(r0));
    chk("dout0", dout0, mdout);
    chk("pend0", 32'(pend0), p);
    chk("rdy0", 32'(if0.wr_ready), 32'(mready));
    chk("busy0", 32'(busy0), 32'((p != 0) || e0));
    chk("be1", 32'(be1), 32'(e1));
    chk("re1", 32'(re1), 32'(r1));
    chk("dout1", dout1, mdout);
    chk("pend1", 32'(pend1), p);
    chk("rdy1", 32'(if1.wr_ready), 32'(mready));
    chk("busy1", 32'(busy1), 32'((p != 0) || e1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit vv, input logic [2:0] aa,
                       input logic [31:0] dd);
    v = vv;
    a = aa;
    d = dd;
  endtask

  initial begin
    maxpend = 0;
    model_reset();
    // reset with valid asserted
    rst_n = 1'b0;
    drive(1'b1, 3'd5, 32'hA5A5A5A5);
    #2;
    repeat (3) step();
    @(negedge clk);
    drive(1'b0, 3'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    check_all();
    step();
    chk("ready_after_release", 32'(if0.wr_ready), 32'd1);

    // single write R7
    drive(1'b1, 3'd7, 32'h00001111);
    step();
    drive(1'b0, 3'd0, 32'h0);
    chk("lat_single", 32'(be1), 32'(BYP));
    if (!BYP) step();
    chk("single_re", 32'(re1), 32'h80);
    step();
    chk("single_be_off", 32'(be1), 32'd0);
    chk("rb_r7", rb1[7], 32'h00001111);

    // burst R1..R6
    maxpend = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 3'(i), 32'h100 + 32'(i));
      step();
    end
    drive(1'b0, 3'd0, 32'h0);
    repeat (2) step();
    chk("burst_maxpend", 32'(maxpend), BYP ? 32'd0 : 32'd1);
    chk("rb_r6", rb1[6], 32'h106);

    // R0 handling
    drive(1'b1, 3'd0, 32'hDEADBEEF);
    step();
    drive(1'b0, 3'd0, 32'h0);
    repeat (2) step();
    chk("rb0_r0", rb0[0], 32'h0);
    chk("rb1_r0", rb1[0], 32'hDEADBEEF);

    // reset in the middle of a queued sequence
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(2 + i), 32'h2000 + 32'(i));
      step();
    end
    drive(1'b0, 3'd0, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1'b1, 3'd3, 32'h33333333);
    step();
    drive(1'b0, 3'd0, 32'h0);
    chk("lat_after_reset", 32'(be1), 32'(BYP));
    repeat (2) step();
    chk("rb_r3", rb1[3], 32'h33333333);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            $urandom());
      step();
    end
    drive(1'b0, 3'd0, 32'h0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
